// File: rtl/reg_file_wb.sv
// Integer register file x0..x31 fed by the writeback mux, with two combinational
// decode read ports, write-through bypass and a registered observation copy of a0.
module reg_file_wb #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0]   SP_RESET   = DATA_WIDTH'(32'h0001FFFC)
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iRegWriteW,
    input  logic [ADDR_WIDTH-1:0] iRdW,
    input  logic [DATA_WIDTH-1:0] iResultW,
    input  logic [ADDR_WIDTH-1:0] iRs1D,
    input  logic [ADDR_WIDTH-1:0] iRs2D,
    output logic [DATA_WIDTH-1:0] oRD1D,
    output logic [DATA_WIDTH-1:0] oRD2D,
    output logic [DATA_WIDTH-1:0] oA0
);

    localparam int unsigned           DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] a0_q;

    assign wr_en = iRegWriteW && (iRdW != '0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (ADDR_WIDTH'(i) == SP_IDX) ? SP_RESET : '0;
            end
            a0_q <= '0;
        end else begin
            if (wr_en) begin
                regs[iRdW] <= iResultW;
            end
            // Track x10 as it will read after this edge, folding in a same-edge write.
            a0_q <= (wr_en && iRdW == A0_IDX) ? iResultW : regs[A0_IDX];
        end
    end

    always_comb begin
        oRD1D = regs[iRs1D];
        if (iRs1D == '0) begin
            oRD1D = '0;
        end else if (iRegWriteW && !iRst && iRdW == iRs1D) begin
            oRD1D = iResultW;
        end
    end

    always_comb begin
        oRD2D = regs[iRs2D];
        if (iRs2D == '0) begin
            oRD2D = '0;
        end else if (iRegWriteW && !iRst && iRdW == iRs2D) begin
            oRD2D = iResultW;
        end
    end

    assign oA0 = a0_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed cases with literal expectations plus
// a per-cycle comparison against an architectural register array model.
module tb_reg_file_wb;

    localparam logic [31:0] SP = 32'h0001FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a0;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          chk_en = 1'b0;

    logic [31:0] mdl [32];
    logic [31:0] mdl_a0;

    reg_file_wb #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .SP_RESET  (SP)
    ) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iRegWriteW(we),
        .iRdW      (rd),
        .iResultW  (res),
        .iRs1D     (rs1),
        .iRs2D     (rs2),
        .oRD1D     (rd1),
        .oRD2D     (rd2),
        .oA0       (a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural read rule: x0 is zero, an in-flight write is visible unless in reset.
    function automatic logic [31:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (we && !rst && rd == rs) return res;
        return mdl[rs];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_a0 = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mdl[2] = SP;
            mdl_a0 = 32'h0;
        end else begin
            if (we && rd != 5'd0) mdl[rd] = res;
            mdl_a0 = mdl[10];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd1", rd1, exp_read(rs1));
            chk("model_rd2", rd2, exp_read(rs2));
            chk("model_a0", a0, mdl_a0);
        end
    end

    // Apply one cycle of inputs just after a rising edge; return mid-cycle.
    task automatic cyc(input logic r, input logic w, input logic [4:0] d, input logic [31:0] v,
                       input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        rst = r; we = w; rd = d; res = v; rs1 = s1; rs2 = s2;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; rd = '0; res = '0; rs1 = '0; rs2 = '0;

        // Reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2, 5);
        chk_en = 1'b1;
        chk("reset_sp", rd1, 32'h0001FFFC);
        chk("reset_x5", rd2, 32'h0);
        chk("reset_a0", a0, 32'h0);

        // Plain write, then write to x0
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0);
        cyc(0, 1, 0, 32'h00001234, 5, 0);
        chk("read_x5", rd1, 32'hDEADBEEF);
        chk("x0_no_bypass", rd2, 32'h0);
        cyc(0, 0, 0, 0, 0, 5);
        chk("x0_after_write", rd1, 32'h0);
        chk("x5_held", rd2, 32'hDEADBEEF);

        // Same-cycle bypass on both ports
        cyc(0, 1, 7, 32'hA5A5A5A5, 7, 7);
        chk("bypass_rd1", rd1, 32'hA5A5A5A5);
        chk("bypass_rd2", rd2, 32'hA5A5A5A5);
        cyc(0, 0, 7, 32'h0, 7, 7);
        chk("stored_rd1", rd1, 32'hA5A5A5A5);
        chk("stored_rd2", rd2, 32'hA5A5A5A5);

        // a0 observation
        cyc(0, 1, 10, 32'h0000002A, 0, 0);
        chk("a0_before_edge", a0, 32'h0);
        cyc(0, 1, 11, 32'h00000077, 10, 11);
        chk("a0_after_edge", a0, 32'h0000002A);
        chk("x10_read", rd1, 32'h0000002A);
        chk("x11_bypass", rd2, 32'h00000077);
        cyc(0, 0, 0, 0, 11, 10);
        chk("a0_after_x11", a0, 32'h0000002A);
        chk("x11_stored", rd1, 32'h00000077);

        // Reset discards in-flight write; reads show pre-reset contents without bypass
        cyc(0, 1, 3, 32'h00000055, 0, 0);
        cyc(1, 1, 3, 32'h00000099, 3, 2);
        chk("rst_rd_stored", rd1, 32'h00000055);
        chk("rst_rd_sp", rd2, 32'h0001FFFC);
        cyc(0, 0, 0, 0, 3, 2);
        chk("post_rst_x3", rd1, 32'h0);
        chk("post_rst_sp", rd2, 32'h0001FFFC);
        chk("post_rst_a0", a0, 32'h0);
        cyc(0, 0, 0, 0, 10, 5);
        chk("post_rst_x10", rd1, 32'h0);
        chk("post_rst_x5", rd2, 32'h0);

        // Directed sweep: write every register, overwrite, then read back via model checks
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 5'(i), 32'h1000_0000 + 32'(i), 5'(i), 5'(31 - i));
        end
        for (int i = 0; i < 32; i++) begin
            cyc(0, (i % 3) != 0, 5'(i), ~(32'(i) << 8), 5'(31 - i), 5'(i));
        end
        cyc(0, 1, 10, 32'hFFFF_FFFF, 10, 10);
        cyc(0, 1, 10, 32'h8000_0001, 10, 2);
        chk("b2b_bypass", rd1, 32'h8000_0001);
        chk("b2b_a0_first", a0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 10, 0);
        chk("b2b_last_wins", rd1, 32'h8000_0001);
        chk("b2b_a0_last", a0, 32'h8000_0001);

        // Mixed traffic on a narrow index range to force collisions, occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                5'($urandom_range(0, 12)), $urandom,
                5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
